// File: rtl/uart_rx_64.sv
// 8N1 UART receiver that packs eight consecutive bytes (first byte in [63:56]) into a 64-bit word.
// Optional inter-byte idle timeout is enabled by defining RX_TIMEOUT_EN.
module uart_rx_64 #(
  parameter int unsigned CLK_F    = 50_000_000,
  parameter int unsigned UART_BPS = 115200,
  parameter int unsigned CLK_GOAL = CLK_F / UART_BPS
`ifdef RX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_BITS = 20
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  output logic [63:0] data_out_64,
  output logic        data_out_done,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(CLK_GOAL);
  localparam logic [TW-1:0] HalfEnd = TW'(CLK_GOAL / 2 - 1);
  localparam logic [TW-1:0] BitEnd  = TW'(CLK_GOAL - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        state_q, state_d;
  logic          rxd_meta, rxd_sync, rxd_prev;
  logic          falling;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [55:0]   word_buf_q, word_buf_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d, byte_cnt_rx;
  logic [63:0]   data_d;
  logic          done_d, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign falling = rxd_prev & ~rxd_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (falling) state_d = StStart;
      // A line already back high at mid start bit was a glitch, not a frame.
      StStart: if (timer_q == HalfEnd) state_d = rxd_sync ? StIdle : StData;
      StData:  if (timer_q == BitEnd && bit_idx_q == 3'd7) state_d = StStop;
      StStop:  if (timer_q == BitEnd) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    word_buf_d  = word_buf_q;
    byte_cnt_rx = byte_cnt_q;
    data_d      = data_out_64;
    done_d      = 1'b0;
    ferr_d      = 1'b0;
    unique case (state_q)
      StIdle: timer_d = '0;
      StStart: begin
        if (timer_q == HalfEnd) begin
          timer_d   = '0;
          bit_idx_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StData: begin
        if (timer_q == BitEnd) begin
          timer_d            = '0;
          shift_d[bit_idx_q] = rxd_sync;
          bit_idx_d          = bit_idx_q + 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StStop: begin
        if (timer_q == BitEnd) begin
          timer_d = '0;
          if (rxd_sync) begin
            word_buf_d  = {word_buf_q[47:0], shift_q};
            byte_cnt_rx = byte_cnt_q + 1'b1;
            if (byte_cnt_q == 3'd7) begin
              data_d = {word_buf_q, shift_q};
              done_d = 1'b1;
            end
          end else begin
            ferr_d      = 1'b1;
            byte_cnt_rx = '0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: timer_d = '0;
    endcase
  end

`ifdef RX_TIMEOUT_EN
  localparam int unsigned IdleLimit = TIMEOUT_BITS * CLK_GOAL;
  localparam int unsigned IW = $clog2(IdleLimit);
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          idle_expire;

  // The counter only runs while a partial word is parked in IDLE.
  always_comb begin
    idle_cnt_d  = '0;
    idle_expire = 1'b0;
    if (state_q == StIdle && byte_cnt_q != 3'd0 && !falling) begin
      if (idle_cnt_q == IW'(IdleLimit - 1)) idle_expire = 1'b1;
      else idle_cnt_d = idle_cnt_q + 1'b1;
    end
    byte_cnt_d = idle_expire ? 3'd0 : byte_cnt_rx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
`else
  assign byte_cnt_d = byte_cnt_rx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q       <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      word_buf_q    <= '0;
      byte_cnt_q    <= '0;
      data_out_64   <= '0;
      data_out_done <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      word_buf_q    <= word_buf_d;
      byte_cnt_q    <= byte_cnt_d;
      data_out_64   <= data_d;
      data_out_done <= done_d;
      frame_err     <= ferr_d;
    end
  end

endmodule

// File: doc/uart_rx_64.md
# uart_rx_64

Serial-to-parallel receiving end of the 64-bit UART link. Samples an 8N1 UART line, recovers bytes, and assembles eight consecutive bytes into one 64-bit word. Presents the word with a one-cycle done strobe. Sits between the board RX pin (or a loop-back from the 64-bit transmitter) and the word consumer.

## Interface
- CLK_F, 50_000_000: system clock frequency in Hz.
- UART_BPS, 115200: line baud rate.
- CLK_GOAL, CLK_F / UART_BPS (434): clocks per bit period.
- TIMEOUT_BITS, 20: idle bit periods tolerated between bytes of one word (used only with RX_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- uart_rxd  input  1  asynchronous serial line; idles high.
- data_out_64  output  64  last completed word; first received byte in [63:56], eighth in [7:0].
- data_out_done  output  1  one-cycle pulse when data_out_64 is updated.
- frame_err  output  1  one-cycle pulse on a failed stop bit.

## Operation
- uart_rxd passes through a 2-FF synchronizer, then one more register for edge detection. A falling edge is a synchronized high-to-low transition.
- The FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge, go to START and clear the bit-timer.
  - START: at timer = CLK_GOAL/2 − 1, sample the line. If it is 0, go to DATA and clear the timer and bit index. If it is 1, treat it as a glitch and return to IDLE; no error is flagged.
  - DATA: at timer = CLK_GOAL − 1, sample the line into shift bit [index], LSB first, and clear the timer. After index 7, go to STOP.
  - STOP: at timer = CLK_GOAL − 1, sample the line.
    - If it is 1, the byte is valid. Shift it into the word buffer (buffer ← {buffer[55:0], byte}) and increment byte_cnt.
    - If it is 0, pulse frame_err, discard the partial word (byte_cnt ← 0), and keep the buffer contents unused.
    - In either case, return to IDLE.
- byte_cnt is 3 bits. When a valid byte arrives with byte_cnt = 7:
  - copy {buffer[55:0], byte} to data_out_64;
  - pulse data_out_done;
  - byte_cnt wraps to 0.
- Timer width is $clog2(CLK_GOAL) bits and never exceeds CLK_GOAL − 1.
- A falling edge seen while not in IDLE is ignored.
- Reset mid-frame aborts the byte and the partial word immediately. Outputs take their reset values.

## Timing
- Reset values: data_out_64 = 0, data_out_done = 0, frame_err = 0, FSM = IDLE, byte_cnt = 0, synchronizer flops = 1.
- Sampling point: mid-bit. The falling edge is seen 3 clk after the pin edge.
- data_out_done and data_out_64 are registered. They change on the clock edge after the eighth stop-bit sample: about 9.5 bit periods + 4 clk after the eighth start edge.
- data_out_64 holds until the next completed word. It is never partially updated.
- Back-to-back frames with zero idle time are supported. IDLE is re-entered mid-stop-bit, so the next start edge is caught.
- data_out_done and frame_err are never asserted in the same cycle.

## Configuration
- RX_TIMEOUT_EN defined:
  - When byte_cnt ≠ 0 and the FSM is in IDLE, an idle counter runs.
  - After TIMEOUT_BITS × CLK_GOAL clocks without a falling edge, byte_cnt ← 0 and the partial word is silently discarded. No output pulse is produced.
  - The idle counter clears on any falling edge and on reset.
- RX_TIMEOUT_EN undefined: no idle counter exists. A partial word waits indefinitely for its remaining bytes.

## Test plan
- Nominal word:
  - Stimulus: send bytes 2d,7e,66,09,1e,d0,a4,03 at 115200 8N1.
  - Required: exactly one data_out_done; data_out_64 = 64'h2d7e66091ed0a403; frame_err never pulses.
- Back-to-back words:
  - Stimulus: send 64'hd253328dd2c0fc3c then 64'h8162476652bdd1d0 with zero inter-frame gap.
  - Required: two done pulses with those values in order.
- Start glitch:
  - Stimulus: drive uart_rxd low for 100 clk, then high; then send a full word 64'h0123456789abcdef.
  - Required: the glitch produces no byte and no error; the word is received intact.
- Framing error:
  - Stimulus: during the third byte of a word, force the stop bit to 0; then send a full word 64'hfedcba9876543210.
  - Required: one frame_err pulse, no done for the aborted word; next done carries 64'hfedcba9876543210.
- Reset mid-word:
  - Stimulus: assert rst during the fifth byte, release, then send a full word.
  - Required: outputs read 0 during reset; the next done carries the new word with no stale bytes.
- Timeout (RX_TIMEOUT_EN defined):
  - Stimulus: send 3 bytes, idle for 25 bit periods, then send 8 bytes 11..88.
  - Required: data_out_64 = 64'h1122334455667788.
  - Without the macro, the same stimulus yields the first 3 bytes followed by 11..55 on the first done.
